// File: rtl/lbp_gray_mem_arbiter_pkg.sv
// Shared constants and types for the gray-image RAM arbiter slice.
package lbp_gray_mem_arbiter_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;
endpackage

// File: rtl/lbp_gray_mem_arbiter_if.sv
// Requester A/B handshakes plus the single-port RAM macro pins, as seen by the arbiter.
interface lbp_gray_mem_arbiter_if;
  import lbp_gray_mem_arbiter_pkg::*;

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_grant;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_grant;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_grant, a_rvalid, a_rdata, b_grant, b_rvalid, b_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_grant, a_rvalid, a_rdata, b_grant, b_rvalid, b_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lbp_gray_mem_arbiter_rr_pick.sv
// Two-way pick: a lone requester wins; under contention the owner keeps the RAM
// until its burst cap is hit, and with no owner the requester not served last wins.
module lbp_gray_mem_arbiter_rr_pick
  import lbp_gray_mem_arbiter_pkg::*;
(
  input  logic   a_req,
  input  logic   b_req,
  input  owner_t owner,
  input  owner_t last,
  input  logic   cnt_at_max,
  output logic   pick_a,
  output logic   pick_b
);

  // Combinational grant decision.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (a_req && !b_req) begin
      pick_a = 1'b1;
    end else if (b_req && !a_req) begin
      pick_b = 1'b1;
    end else if (a_req && b_req) begin
      case (owner)
        OWN_A: begin
          pick_a = ~cnt_at_max;
          pick_b = cnt_at_max;
        end
        OWN_B: begin
          pick_a = cnt_at_max;
          pick_b = ~cnt_at_max;
        end
        default: begin
          pick_a = (last != OWN_A);
          pick_b = (last == OWN_A);
        end
      endcase
    end else begin
      pick_a = 1'b0;
      pick_b = 1'b0;
    end
  end

endmodule

// File: rtl/lbp_gray_mem_arbiter.sv
// Shares one single-port gray RAM between the LBP engine (A, read-only) and the host (B),
// with same-cycle grants, round-robin ties and a bounded burst hold.
module lbp_gray_mem_arbiter
  import lbp_gray_mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  lbp_gray_mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  owner_t            owner_r;
  owner_t            last_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              a_rvalid_r;
  logic              b_rvalid_r;
  logic              pick_a_s;
  logic              pick_b_s;
  logic              a_grant_s;
  logic              b_grant_s;
  logic              cnt_at_max_s;
  logic              mem_cs_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign cnt_at_max_s = (cnt_r == CNT_W'(MAX_BURST));

  lbp_gray_mem_arbiter_rr_pick u_pick (
    .a_req      (bus.a_req),
    .b_req      (bus.b_req),
    .owner      (owner_r),
    .last       (last_r),
    .cnt_at_max (cnt_at_max_s),
    .pick_a     (pick_a_s),
    .pick_b     (pick_b_s)
  );

  // Nothing reaches the RAM while reset is held.
  assign a_grant_s = pick_a_s & ~reset;
  assign b_grant_s = pick_b_s & ~reset;

  // Ownership, burst count and read-return pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r    <= OWN_NONE;
      last_r     <= OWN_B;
      cnt_r      <= CNT_W'(1);
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
    end else begin
      a_rvalid_r <= a_grant_s;
      b_rvalid_r <= b_grant_s & ~bus.b_we;
      if (a_grant_s) begin
        last_r <= OWN_A;
        if (owner_r == OWN_A) begin
          cnt_r <= cnt_at_max_s ? cnt_r : cnt_r + CNT_W'(1);
        end else begin
          owner_r <= OWN_A;
          cnt_r   <= CNT_W'(1);
        end
      end else if (b_grant_s) begin
        last_r <= OWN_B;
        if (owner_r == OWN_B) begin
          cnt_r <= cnt_at_max_s ? cnt_r : cnt_r + CNT_W'(1);
        end else begin
          owner_r <= OWN_B;
          cnt_r   <= CNT_W'(1);
        end
      end else begin
        owner_r <= OWN_NONE;
        cnt_r   <= CNT_W'(1);
      end
    end
  end

  // RAM pin mux driven by whichever requester holds this cycle's grant.
  always_comb begin
    mem_cs_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (a_grant_s) begin
      mem_cs_s   = 1'b1;
      mem_addr_s = bus.a_addr;
    end else if (b_grant_s) begin
      mem_cs_s    = 1'b1;
      mem_we_s    = bus.b_we;
      mem_addr_s  = bus.b_addr;
      mem_wdata_s = bus.b_wdata;
    end else begin
      mem_cs_s = 1'b0;
    end
  end

  assign bus.a_grant   = a_grant_s;
  assign bus.b_grant   = b_grant_s;
  assign bus.mem_cs    = mem_cs_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  // A read launched just before reset is squashed rather than returned.
  assign bus.a_rvalid  = a_rvalid_r & ~reset;
  assign bus.b_rvalid  = b_rvalid_r & ~reset;
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.b_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_lbp_gray_mem_arbiter.sv
// Directed bench: RAM model, shadow-memory scoreboard of read data, grant/mux checks.
module tb_lbp_gray_mem_arbiter;
  import lbp_gray_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  lbp_gray_mem_arbiter_if bus ();

  lbp_gray_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_pix(input logic [13:0] a);
    return a[7:0] ^ {2'b10, a[13:8]};
  endfunction

  // RAM macro model: one-cycle read latency, unwritten cells hold a fixed pattern.
  logic [7:0] ram     [0:16383];
  bit         written [0:16383];
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= written[bus.mem_addr] ? ram[bus.mem_addr] : init_pix(bus.mem_addr);
      end
    end
  end

  logic [7:0] shadow [int];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  bit pend_a = 1'b0;
  bit pend_b = 1'b0;

  function automatic logic [7:0] shadow_rd(input logic [13:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_pix(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check last cycle's returns, then this cycle's grants and RAM pins.
  task automatic tick(input string tag, input logic ega, input logic egb);
    logic ga;
    logic gb;
    @(negedge clk);
    if (reset) begin
      chk({tag, ":a_rvalid"}, {31'd0, bus.a_rvalid}, 32'd0);
      chk({tag, ":b_rvalid"}, {31'd0, bus.b_rvalid}, 32'd0);
      qa.delete();
      qb.delete();
    end else begin
      chk({tag, ":a_rvalid"}, {31'd0, bus.a_rvalid}, {31'd0, pend_a});
      chk({tag, ":b_rvalid"}, {31'd0, bus.b_rvalid}, {31'd0, pend_b});
      if (pend_a && qa.size() > 0) chk({tag, ":a_rdata"}, {24'd0, bus.a_rdata}, {24'd0, qa.pop_front()});
      if (pend_b && qb.size() > 0) chk({tag, ":b_rdata"}, {24'd0, bus.b_rdata}, {24'd0, qb.pop_front()});
    end
    pend_a = 1'b0;
    pend_b = 1'b0;
    ga = ega & ~reset;
    gb = egb & ~reset;
    chk({tag, ":a_grant"}, {31'd0, bus.a_grant}, {31'd0, ga});
    chk({tag, ":b_grant"}, {31'd0, bus.b_grant}, {31'd0, gb});
    chk({tag, ":mem_cs"}, {31'd0, bus.mem_cs}, {31'd0, ga | gb});
    chk({tag, ":mem_we"}, {31'd0, bus.mem_we}, {31'd0, gb & bus.b_we});
    chk({tag, ":mem_addr"}, {18'd0, bus.mem_addr},
        ga ? {18'd0, bus.a_addr} : (gb ? {18'd0, bus.b_addr} : 32'd0));
    chk({tag, ":mem_wdata"}, {24'd0, bus.mem_wdata}, gb ? {24'd0, bus.b_wdata} : 32'd0);
    if (ga) begin
      qa.push_back(shadow_rd(bus.a_addr));
      pend_a = 1'b1;
    end
    if (gb) begin
      if (bus.b_we) begin
        shadow[int'(bus.b_addr)] = bus.b_wdata;
      end else begin
        qb.push_back(shadow_rd(bus.b_addr));
        pend_b = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    bus.a_req   = 1'b0;
    bus.a_addr  = 14'd0;
    bus.b_req   = 1'b0;
    bus.b_we    = 1'b0;
    bus.b_addr  = 14'd0;
    bus.b_wdata = 8'd0;

    // Reset state, including a request held during reset.
    tick("rst0", 1'b0, 1'b0);
    bus.a_req = 1'b1;
    tick("rst1", 1'b0, 1'b0);
    reset     = 1'b0;
    bus.a_req = 1'b0;
    tick("idle0", 1'b0, 1'b0);

    // 1: A streams addresses 0..8.
    bus.a_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.a_addr = 14'(i);
      tick("t1_a", 1'b1, 1'b0);
    end
    bus.a_req = 1'b0;
    tick("t1_end", 1'b0, 1'b0);

    // 2: host write followed by an engine read of the same cell.
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b1;
    bus.b_addr  = 14'h0081;
    bus.b_wdata = 8'h5A;
    tick("t2_wr", 1'b0, 1'b1);
    bus.b_req  = 1'b0;
    bus.b_we   = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_addr = 14'h0081;
    tick("t2_rd", 1'b1, 1'b0);
    bus.a_req = 1'b0;
    tick("t2_end", 1'b0, 1'b0);

    // 3: continuous contention from reset: AAAA BBBB AAAA.
    reset       = 1'b1;
    bus.a_req   = 1'b1;
    bus.b_req   = 1'b1;
    bus.a_addr  = 14'h0200;
    bus.b_addr  = 14'h0300;
    bus.b_we    = 1'b0;
    tick("t3_rst", 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick("t3_rr", ((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick("t3_end", 1'b0, 1'b0);

    // 4: A holds, B arrives, A drops; B's burst then starts from 1.
    bus.a_req = 1'b1;
    tick("t4_a1", 1'b1, 1'b0);
    tick("t4_a2", 1'b1, 1'b0);
    bus.b_req = 1'b1;
    tick("t4_a3", 1'b1, 1'b0);
    bus.a_req = 1'b0;
    tick("t4_b1", 1'b0, 1'b1);
    bus.a_req = 1'b1;
    tick("t4_b2", 1'b0, 1'b1);
    tick("t4_b3", 1'b0, 1'b1);
    tick("t4_b4", 1'b0, 1'b1);
    tick("t4_a", 1'b1, 1'b0);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick("t4_end", 1'b0, 1'b0);

    // 5: host read then reset: return is dropped, no grants during reset.
    bus.b_req  = 1'b1;
    bus.b_we   = 1'b0;
    bus.b_addr = 14'h0081;
    tick("t5_rd", 1'b0, 1'b1);
    reset     = 1'b1;
    bus.b_req = 1'b0;
    tick("t5_rst0", 1'b0, 1'b0);
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    tick("t5_rst1", 1'b0, 1'b0);
    reset     = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick("t5_after", 1'b0, 1'b0);

    // 6: last=A, idle gap, then a tie goes to B.
    bus.a_req  = 1'b1;
    bus.a_addr = 14'h3FFF;
    tick("t6_a", 1'b1, 1'b0);
    bus.a_req = 1'b0;
    for (int i = 0; i < 3; i++) tick("t6_idle", 1'b0, 1'b0);
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.b_addr = 14'h2000;
    tick("t6_tie", 1'b0, 1'b1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick("t6_end", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
